// File: rtl/pe_outcha_multi_obuffer.sv
// pe_outcha_multi_obuffer
// Turns groups of NUM_LANES output-channel pixels from a parallel PE array
// into one pixel per cycle. Valid/ready on both sides. The final group of
// a frame may be short (LAST_LANES pixels). o_last marks the frame's last pixel.
// A new group can be loaded in the same cycle that the previous group's
// last lane is taken, so a continuous stream has no bubbles.

module pe_outcha_multi_obuffer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int IN_WIDTH   = 513,
    parameter int IN_HEIGHT  = 257,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int DILATION_0 = 2,
    parameter int DILATION_1 = 2,
    parameter int PADDING_0  = 2,
    parameter int PADDING_1  = 2,
    parameter int STRIDE_0   = 1,
    parameter int STRIDE_1   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] i_data,
    input  logic                            i_valid,
    output logic                            i_ready,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic                            o_last
);

    // Frame geometry derived from the conv layer shape.
    localparam int OUT_H      = (IN_HEIGHT + 2*PADDING_0 - DILATION_0*(KERNEL_0-1) - 1) / STRIDE_0 + 1;
    localparam int OUT_W      = (IN_WIDTH  + 2*PADDING_1 - DILATION_1*(KERNEL_1-1) - 1) / STRIDE_1 + 1;
    localparam int OUT_PIXELS = OUT_H * OUT_W;
    localparam int NUM_GROUPS = (OUT_PIXELS + NUM_LANES - 1) / NUM_LANES;
    localparam int LAST_REM   = OUT_PIXELS % NUM_LANES;
    localparam int LAST_LANES = (LAST_REM == 0) ? NUM_LANES : LAST_REM;

    // The lane counter only has to reach NUM_LANES-1. The lane limit has to
    // hold NUM_LANES itself, so it may need one more bit.
    localparam int LW  = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1;
    localparam int LLW = $clog2(NUM_LANES + 1);
    localparam int GW  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [LLW-1:0] LIMIT_FULL = LLW'(NUM_LANES);
    localparam logic [LLW-1:0] LIMIT_LAST = LLW'(LAST_LANES);
    localparam logic [GW-1:0]  GRP_LAST   = GW'(NUM_GROUPS - 1);

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes_q;
    logic [LW-1:0]                        lane_cnt;
    logic [LLW-1:0]                       lane_limit;
    logic [GW-1:0]                        grp_cnt;
    logic                                 full;
    logic                                 is_final;

    logic [LLW-1:0] lane_last_idx;
    logic           last_lane;
    logic           accept;
    logic           drain;
    logic           grp_wrap;

    assign lane_last_idx = lane_limit - LLW'(1);
    assign last_lane     = (LLW'(lane_cnt) == lane_last_idx);
    assign grp_wrap      = (grp_cnt == GRP_LAST);

    // Ready does not depend on i_valid. The only path from an input to an
    // output is o_ready -> i_ready, which lets a new group load while the
    // last lane of the current group is taken.
    assign i_ready = ~full | (o_ready & last_lane);
    assign accept  = i_valid & i_ready;
    assign drain   = full & o_ready;

    assign o_data  = lanes_q[lane_cnt];
    assign o_valid = full;
    assign o_last  = full & is_final & last_lane;

    // Group register, lane/group counters and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q    <= '0;
            lane_cnt   <= '0;
            lane_limit <= LIMIT_FULL;
            grp_cnt    <= '0;
            full       <= 1'b0;
            is_final   <= 1'b0;
        end else if (accept) begin
            lanes_q    <= i_data;
            lane_cnt   <= '0;
            full       <= 1'b1;
            lane_limit <= grp_wrap ? LIMIT_LAST : LIMIT_FULL;
            is_final   <= grp_wrap;
            grp_cnt    <= grp_wrap ? '0 : grp_cnt + GW'(1);
        end else if (drain) begin
            if (last_lane) begin
                full <= 1'b0;
            end else begin
                lane_cnt <= lane_cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_outcha_multi_obuffer.sv
// Directed bench for pe_outcha_multi_obuffer. Two instances are used:
// 4 lanes with a 5x5 output (short final group), and 2 lanes with a 4x4
// output (even split). Expected pixels go into a queue as groups are driven
// and are popped on each output handshake.

module tb_pe_outcha_multi_obuffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [31:0] i_data4;
    logic        i_valid4, i_ready4;
    logic [7:0]  o_data4;
    logic        o_valid4, o_ready4, o_last4;

    logic [15:0] i_data2;
    logic        i_valid2, i_ready2;
    logic [7:0]  o_data2;
    logic        o_valid2, o_ready2, o_last2;

    // Bench-side frame model for the two configurations.
    localparam int PIX4 = 25;
    localparam int NG4  = (PIX4 + 3) / 4;
    localparam int LL4  = (PIX4 % 4 == 0) ? 4 : PIX4 % 4;
    localparam int PIX2 = 16;
    localparam int NG2  = (PIX2 + 1) / 2;
    localparam int LL2  = (PIX2 % 2 == 0) ? 2 : PIX2 % 2;

    pe_outcha_multi_obuffer #(
        .DATA_WIDTH(8), .NUM_LANES(4), .IN_WIDTH(5), .IN_HEIGHT(5),
        .KERNEL_0(3), .KERNEL_1(3), .DILATION_0(2), .DILATION_1(2),
        .PADDING_0(2), .PADDING_1(2), .STRIDE_0(1), .STRIDE_1(1)
    ) dut4 (
        .clk(clk), .rst(rst),
        .i_data(i_data4), .i_valid(i_valid4), .i_ready(i_ready4),
        .o_data(o_data4), .o_valid(o_valid4), .o_ready(o_ready4), .o_last(o_last4)
    );

    pe_outcha_multi_obuffer #(
        .DATA_WIDTH(8), .NUM_LANES(2), .IN_WIDTH(4), .IN_HEIGHT(4),
        .KERNEL_0(3), .KERNEL_1(3), .DILATION_0(2), .DILATION_1(2),
        .PADDING_0(2), .PADDING_1(2), .STRIDE_0(1), .STRIDE_1(1)
    ) dut2 (
        .clk(clk), .rst(rst),
        .i_data(i_data2), .i_valid(i_valid2), .i_ready(i_ready2),
        .o_data(o_data2), .o_valid(o_valid2), .o_ready(o_ready2), .o_last(o_last2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] q4[$];
    logic [8:0] q2[$];
    logic [8:0] e4, e2;
    int out_cnt4 = 0, out_cnt2 = 0;
    int first4 = 0, lastc4 = 0;
    int mark4 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor for the 4-lane instance, sampled mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (o_valid4 === 1'b0) check("last_idle4", {31'd0, o_last4}, 32'd0);
        if (o_valid4 === 1'b1 && o_ready4 === 1'b1) begin
            total++;
            assert (q4.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out4 observed=%0h expected=none", o_data4);
            end
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("data4", {24'd0, o_data4}, {24'd0, e4[7:0]});
                check("last4", {31'd0, o_last4}, {31'd0, e4[8]});
            end
            if (out_cnt4 == mark4) first4 = cyc;
            lastc4 = cyc;
            out_cnt4++;
        end
    end

    // Output monitor for the 2-lane instance.
    always begin
        @(negedge clk);
        #1;
        if (o_valid2 === 1'b1 && o_ready2 === 1'b1) begin
            total++;
            assert (q2.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out2 observed=%0h expected=none", o_data2);
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                check("data2", {24'd0, o_data2}, {24'd0, e2[7:0]});
                check("last2", {31'd0, o_last2}, {31'd0, e2[8]});
            end
            out_cnt2++;
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_grp4(input logic [31:0] d, inout int iters);
        bit hs;
        hs = 1'b0;
        i_data4  = d;
        i_valid4 = 1'b1;
        for (int t = 0; t < 100 && !hs; t++) begin
            #1;
            hs = i_ready4;
            iters++;
            @(negedge clk);
        end
        check("accept_timeout4", {31'd0, hs}, 32'd1);
        i_valid4 = 1'b0;
    endtask

    task automatic send_grp2(input logic [15:0] d);
        bit hs;
        hs = 1'b0;
        i_data2  = d;
        i_valid2 = 1'b1;
        for (int t = 0; t < 100 && !hs; t++) begin
            #1;
            hs = i_ready2;
            @(negedge clk);
        end
        check("accept_timeout2", {31'd0, hs}, 32'd1);
        i_valid2 = 1'b0;
    endtask

    // One full 4-lane frame. Lanes past the short tail hold marker values
    // that must never come out.
    task automatic send_frame4(input int base, output int iters);
        logic [31:0] d;
        logic [7:0]  v;
        int          lim;
        iters = 0;
        for (int g = 0; g < NG4; g++) begin
            lim = (g == NG4 - 1) ? LL4 : 4;
            for (int k = 0; k < 4; k++) begin
                v = (k < lim) ? 8'(base + g*4 + k) : 8'(8'hE0 + k);
                d[k*8 +: 8] = v;
                if (k < lim) q4.push_back({(g == NG4 - 1 && k == lim - 1), v});
            end
            send_grp4(d, iters);
        end
    endtask

    task automatic wait_drain4();
        for (int t = 0; t < 300 && q4.size() != 0; t++) @(negedge clk);
        check("drain4", q4.size(), 32'd0);
    endtask

    int  it_a, it_b;
    bit  seen;
    logic [15:0] d2;

    initial begin
        rst = 1'b1;
        i_valid4 = 1'b0; i_data4 = '0; o_ready4 = 1'b1;
        i_valid2 = 1'b0; i_data2 = '0; o_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid4", {31'd0, o_valid4}, 32'd0);
        check("rst_last4",  {31'd0, o_last4},  32'd0);
        check("rst_data4",  {24'd0, o_data4},  32'd0);
        check("rst_iready4",{31'd0, i_ready4}, 32'd1);
        check("rst_valid2", {31'd0, o_valid2}, 32'd0);
        check("rst_data2",  {24'd0, o_data2},  32'd0);
        check("rst_iready2",{31'd0, i_ready2}, 32'd1);
        @(negedge clk);

        // Continuous streaming, one frame of pixels 0..24.
        mark4 = out_cnt4;
        send_frame4(0, it_a);
        wait_drain4();
        check("frame_a_count", out_cnt4 - mark4, 32'd25);
        check("frame_a_span",  lastc4 - first4, 32'd24);
        check("frame_a_accept_cycles", it_a, 32'd25);

        // Two back-to-back frames with a 5-cycle stall on pixel 2.
        mark4 = out_cnt4;
        fork
            begin
                send_frame4(0, it_a);
                send_frame4(25, it_b);
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(negedge clk);
                    #1;
                    seen = (o_valid4 === 1'b1 && o_ready4 === 1'b1 && o_data4 === 8'd1);
                end
                check("bp_reach", {31'd0, seen}, 32'd1);
                @(negedge clk);
                o_ready4 = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    check("bp_data",   {24'd0, o_data4},  32'd2);
                    check("bp_valid",  {31'd0, o_valid4}, 32'd1);
                    check("bp_iready", {31'd0, i_ready4}, 32'd0);
                    @(negedge clk);
                end
                o_ready4 = 1'b1;
            end
        join
        wait_drain4();
        check("frames_bc_count", out_cnt4 - mark4, 32'd50);

        // Reset after two lanes of a group have been emitted.
        mark4 = out_cnt4;
        q4.push_back({1'b0, 8'hA0});
        q4.push_back({1'b0, 8'hA1});
        q4.push_back({1'b0, 8'hA2});
        q4.push_back({1'b0, 8'hA3});
        send_grp4(32'hA3A2A1A0, it_a);
        for (int t = 0; t < 50 && out_cnt4 < mark4 + 2; t++) @(negedge clk);
        check("mid_reach", out_cnt4 - mark4, 32'd2);
        rst = 1'b1;
        o_ready4 = 1'b0;
        q4.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid",  {31'd0, o_valid4}, 32'd0);
        check("mid_rst_data",   {24'd0, o_data4},  32'd0);
        check("mid_rst_iready", {31'd0, i_ready4}, 32'd1);
        @(negedge clk);
        o_ready4 = 1'b1;
        mark4 = out_cnt4;
        send_frame4(100, it_a);
        wait_drain4();
        check("post_rst_count", out_cnt4 - mark4, 32'd25);

        // Even split: 2 lanes, 16 pixels, o_last on pixel 15.
        for (int g = 0; g < NG2; g++) begin
            for (int k = 0; k < 2; k++) begin
                d2[k*8 +: 8] = 8'(8'h40 + g*2 + k);
                q2.push_back({(g == NG2 - 1 && k == LL2 - 1), 8'(8'h40 + g*2 + k)});
            end
            send_grp2(d2);
        end
        for (int t = 0; t < 100 && q2.size() != 0; t++) @(negedge clk);
        check("drain2", q2.size(), 32'd0);
        check("even_count", out_cnt2, 32'd16);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
